// File: rtl/dmem_if.sv
// ============================================================================
// Module   : dmem_if
// Brief    : Request/response bundle between the core MEM stage and dmem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dmem_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_fun3;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_fun3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_fun3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Wait-state RV32I data memory; byte/half/word loads and stores.
//            Optional macro DMEM_ERR_CHECK_EN enables misalign/illegal-fun3 errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    dmem_if.slave     bus
);

    localparam int         c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);
    localparam logic [1:0] c_SZ_B  = 2'd0;
    localparam logic [1:0] c_SZ_H  = 2'd1;
    localparam logic [1:0] c_SZ_W  = 2'd2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic                    r_write;
    logic [DEPTH_LOG2+1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [2:0]              r_fun3;
    logic [31:0]             r_rdata;
    logic                    r_err;
    logic [31:0]             r_mem [c_DEPTH];

    logic                    w_idle, w_accept, w_commit;
    logic                    w_write;
    logic [DEPTH_LOG2+1:0]   w_addr;
    logic [31:0]             w_wdata;
    logic [2:0]              w_fun3;
    logic [1:0]              w_size;
    logic                    w_fun_ok, w_misal, w_err, w_sx;
    logic [1:0]              w_lane;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [31:0]             w_shifted, w_ld, w_wd;
    logic [3:0]              w_be;
    logic                    w_unused_addr;

    assign w_unused_addr = &{1'b0, bus.req_addr[31:DEPTH_LOG2+2]};

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && bus.req_valid;
    // With zero wait states the access commits on the acceptance edge itself,
    // so the operands come straight from the bus while idle.
    assign w_commit = (w_accept && (c_WAIT == 4'd0)) || ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_write  = w_idle ? bus.req_write : r_write;
    assign w_addr   = w_idle ? bus.req_addr[DEPTH_LOG2+1:0] : r_addr;
    assign w_wdata  = w_idle ? bus.req_wdata : r_wdata;
    assign w_fun3   = w_idle ? bus.req_fun3 : r_fun3;
    assign w_idx    = w_addr[DEPTH_LOG2+1:2];

    always_comb begin
        w_fun_ok = 1'b1;
        w_size   = c_SZ_W;
        if (w_write) begin
            case (w_fun3)
                3'b000:  w_size = c_SZ_B;
                3'b001:  w_size = c_SZ_H;
                3'b010:  w_size = c_SZ_W;
                default: w_fun_ok = 1'b0;
            endcase
        end else begin
            case (w_fun3)
                3'b000, 3'b100: w_size = c_SZ_B;
                3'b001, 3'b101: w_size = c_SZ_H;
                3'b010:         w_size = c_SZ_W;
                default:        w_fun_ok = 1'b0;
            endcase
        end
        w_misal = ((w_size == c_SZ_H) && w_addr[0]) || ((w_size == c_SZ_W) && (w_addr[1:0] != 2'b00));
`ifdef DMEM_ERR_CHECK_EN
        w_err = !w_fun_ok || w_misal;
`else
        w_err = 1'b0;
`endif
        // Lane is always the size-aligned one; misaligned cases are errors when checked.
        case (w_size)
            c_SZ_B:  w_lane = w_addr[1:0];
            c_SZ_H:  w_lane = {w_addr[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
        w_sx      = ~w_fun3[2];
        w_shifted = r_mem[w_idx] >> {w_lane, 3'b000};
        case (w_size)
            c_SZ_B: begin
                w_ld = {{24{w_sx & w_shifted[7]}}, w_shifted[7:0]};
                w_be = 4'b0001 << w_lane;
                w_wd = {4{w_wdata[7:0]}};
            end
            c_SZ_H: begin
                w_ld = {{16{w_sx & w_shifted[15]}}, w_shifted[15:0]};
                w_be = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{w_wdata[15:0]}};
            end
            default: begin
                w_ld = w_shifted;
                w_be = 4'b1111;
                w_wd = w_wdata;
            end
        endcase
    end

    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) w_next = (c_WAIT == 4'd0) ? S_RESP : S_WAIT;
            end
            S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_fun3  <= 3'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr[DEPTH_LOG2+1:0];
                r_wdata <= bus.req_wdata;
                r_fun3  <= bus.req_fun3;
                r_cnt   <= c_WAIT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_write || w_err) ? 32'd0 : w_ld;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= 32'd0;
        end else if (w_commit && w_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed bench with a byte-level memory model for two responders
//            (WAIT_CYCLES=2 and WAIT_CYCLES=0).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_if u_if0 ();
    dmem_if u_if1 ();

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0.slave));
    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));

    logic [7:0]  m_mem [2][1024];
    bit          pend [2];
    int          due [2];
    logic [31:0] exp_rd [2];
    bit          exp_err [2];

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Byte-addressed view of memory; the responder's word layout is not assumed.
    function automatic void model_xact(int d, logic w, logic [31:0] a, logic [31:0] wd,
                                       logic [2:0] f, output logic [31:0] rd, output bit e);
        int unsigned size, base;
        bit          legal, sgn;
        logic [31:0] v;
        if (w) begin
            legal = (f <= 3'd2);
            size  = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
            sgn   = 1'b0;
        end else begin
            legal = (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            size  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
            sgn   = !f[2];
        end
        base = a % 1024;
`ifdef DMEM_ERR_CHECK_EN
        e = !legal || (base % size != 0);
`else
        e    = 1'b0;
        base = base - (base % size);
`endif
        rd = 32'd0;
        if (e) return;
        if (w) begin
            for (int i = 0; i < int'(size); i++) m_mem[d][base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < int'(size); i++) v = v | (32'(m_mem[d][base + i]) << (8 * i));
            if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
        end
    endfunction

    task automatic mon(int d, logic v, logic w, logic [31:0] a, logic [31:0] wd, logic [2:0] f,
                       logic rdy, logic rv, logic [31:0] rd, logic er, logic bsy);
        bit          exp_rdy, hit, e;
        logic [31:0] r;
        if (!rst_n) begin
            pend[d] = 1'b0;
            for (int i = 0; i < 1024; i++) m_mem[d][i] = 8'd0;
            chk($sformatf("dut%0d reset {ready,valid,busy,err}", d), 32'({rdy, rv, bsy, er}), 32'b1000);
            chk($sformatf("dut%0d reset rdata", d), rd, 32'd0);
            return;
        end
        exp_rdy = !pend[d];
        hit     = pend[d] && (cyc == due[d]);
        chk($sformatf("dut%0d req_ready", d), 32'(rdy), 32'(exp_rdy));
        chk($sformatf("dut%0d busy", d), 32'(bsy), 32'(pend[d]));
        chk($sformatf("dut%0d rsp_valid", d), 32'(rv), 32'(hit));
        if (hit) begin
            chk($sformatf("dut%0d rsp_rdata", d), rd, exp_rd[d]);
            chk($sformatf("dut%0d rsp_err", d), 32'(er), 32'(exp_err[d]));
            pend[d] = 1'b0;
        end
        if (exp_rdy && v) begin
            model_xact(d, w, a, wd, f, r, e);
            exp_rd[d]  = r;
            exp_err[d] = e;
            pend[d]    = 1'b1;
            due[d]     = cyc + ((d == 0) ? 2 : 0) + 1;
        end
    endtask

    always @(negedge clk) begin
        mon(0, u_if0.req_valid, u_if0.req_write, u_if0.req_addr, u_if0.req_wdata, u_if0.req_fun3,
            u_if0.req_ready, u_if0.rsp_valid, u_if0.rsp_rdata, u_if0.rsp_err, u_if0.busy);
        mon(1, u_if1.req_valid, u_if1.req_write, u_if1.req_addr, u_if1.req_wdata, u_if1.req_fun3,
            u_if1.req_ready, u_if1.rsp_valid, u_if1.rsp_rdata, u_if1.rsp_err, u_if1.busy);
    end

    task automatic set_req(int d, logic v, logic w, logic [31:0] a, logic [31:0] wd, logic [2:0] f);
        if (d == 0) begin
            u_if0.req_valid = v; u_if0.req_write = w; u_if0.req_addr = a;
            u_if0.req_wdata = wd; u_if0.req_fun3 = f;
        end else begin
            u_if1.req_valid = v; u_if1.req_write = w; u_if1.req_addr = a;
            u_if1.req_wdata = wd; u_if1.req_fun3 = f;
        end
    endtask

    function automatic logic sig_of(int d, bit rsp);
        if (d == 0) return rsp ? u_if0.rsp_valid : u_if0.req_ready;
        return rsp ? u_if1.rsp_valid : u_if1.req_ready;
    endfunction

    task automatic wait_for(int d, bit rsp, string nm, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (sig_of(d, rsp) === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        n_total++;
        n_bad++;
        $display("FAIL %s: timeout waiting for %s, got none, want within 30 cycles", nm, rsp ? "rsp_valid" : "req_ready");
    endtask

    task automatic xact(int d, logic w, logic [31:0] a, logic [31:0] wd, logic [2:0] f,
                        logic [31:0] e_rd, bit e_err, string nm);
        int k;
        bit ok;
        @(posedge clk);
        #1 set_req(d, 1'b1, w, a, wd, f);
        wait_for(d, 1'b0, nm, ok);
        k = cyc;
        @(posedge clk);
        #1 set_req(d, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        if (!ok) return;
        wait_for(d, 1'b1, nm, ok);
        if (!ok) return;
        chk({nm, " latency"}, 32'(cyc - k), (d == 0) ? 32'd3 : 32'd1);
        chk({nm, " rdata"}, (d == 0) ? u_if0.rsp_rdata : u_if1.rsp_rdata, e_rd);
        chk({nm, " err"}, 32'((d == 0) ? u_if0.rsp_err : u_if1.rsp_err), 32'(e_err));
    endtask

`ifdef DMEM_ERR_CHECK_EN
    localparam bit          c_E = 1'b1;
    localparam logic [31:0] c_W20_AFTER_MIS = 32'h1122_F044;
    localparam logic [31:0] c_LH1 = 32'h0;
    localparam logic [31:0] c_LW_BADF = 32'h0;
    localparam logic [31:0] c_W20_AFTER_BADS = 32'h1122_F044;
`else
    localparam bit          c_E = 1'b0;
    localparam logic [31:0] c_W20_AFTER_MIS = 32'hCAFE_F00D;
    localparam logic [31:0] c_LH1 = 32'hFFFF_A5A5;
    localparam logic [31:0] c_LW_BADF = 32'hA5A5_A5A5;
    localparam logic [31:0] c_W20_AFTER_BADS = 32'h1234_5678;
`endif

    initial begin
        int          t [3];
        logic [31:0] r [3];
        bit          ok;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Store dropped by a reset that lands mid-WAIT
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2);
        wait_for(0, 1'b0, "reset-drop accept", ok);
        @(posedge clk);
        #1 set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        xact(0, 0, 32'h10, 0, 3'd2, 32'h0, 1'b0, "lw 0x10 after reset");

        xact(0, 1, 32'h20, 32'h1122_3344, 3'd2, 32'h0, 1'b0, "sw 0x20");
        xact(0, 0, 32'h23, 0, 3'd0, 32'h0000_0011, 1'b0, "lb 0x23");
        xact(0, 0, 32'h22, 0, 3'd1, 32'h0000_1122, 1'b0, "lh 0x22");
        xact(0, 0, 32'h20, 0, 3'd4, 32'h0000_0044, 1'b0, "lbu 0x20");
        xact(0, 1, 32'h21, 32'h0000_00F0, 3'd0, 32'h0, 1'b0, "sb 0x21");
        xact(0, 0, 32'h21, 0, 3'd0, 32'hFFFF_FFF0, 1'b0, "lb 0x21");
        xact(0, 0, 32'h20, 0, 3'd2, 32'h1122_F044, 1'b0, "lw 0x20");
        xact(0, 1, 32'h22, 32'hCAFE_F00D, 3'd2, 32'h0, c_E, "sw misaligned 0x22");
        xact(0, 0, 32'h20, 0, 3'd2, c_W20_AFTER_MIS, 1'b0, "lw 0x20 after misaligned sw");
        xact(0, 1, 32'h400, 32'hA5A5_A5A5, 3'd2, 32'h0, 1'b0, "sw 0x400 wrap");
        xact(0, 0, 32'h0, 0, 3'd2, 32'hA5A5_A5A5, 1'b0, "lw 0x0 wrap");
        xact(0, 0, 32'h1, 0, 3'd1, c_LH1, c_E, "lh misaligned 0x1");
        xact(0, 0, 32'h2, 0, 3'd5, 32'h0000_A5A5, 1'b0, "lhu 0x2");
        xact(0, 0, 32'h0, 0, 3'd3, c_LW_BADF, c_E, "load fun3 011");
        xact(0, 1, 32'h20, 32'h1234_5678, 3'd3, 32'h0, c_E, "store fun3 011");
        xact(0, 0, 32'h20, 0, 3'd2, c_W20_AFTER_BADS, 1'b0, "lw 0x20 after bad store");

        // Zero-wait responder with req_valid held across three requests
        @(posedge clk);
        #1 set_req(1, 1'b1, 1'b1, 32'h4, 32'h1, 3'd2);
        for (int i = 0; i < 3; i++) begin
            wait_for(1, 1'b0, "b2b accept", ok);
            @(posedge clk);
            #1;
            if (i == 0)      set_req(1, 1'b1, 1'b1, 32'h8, 32'h2, 3'd2);
            else if (i == 1) set_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 3'd2);
            else             set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
            wait_for(1, 1'b1, "b2b response", ok);
            t[i] = cyc;
            r[i] = u_if1.rsp_rdata;
        end
        chk("b2b spacing 0-1", 32'(t[1] - t[0]), 32'd2);
        chk("b2b spacing 1-2", 32'(t[2] - t[1]), 32'd2);
        chk("b2b sw rdata", r[0], 32'h0);
        chk("b2b lw rdata", r[2], 32'h1);
        xact(1, 0, 32'h8, 0, 3'd2, 32'h2, 1'b0, "dut1 lw 0x8");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
